score_display: RTL

//  Reader side of the 8-bit score accumulator: captures Q on an update strobe and

---
 rtl/score_display.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/score_display.sv
// Score reader: captures the accumulator value, converts it to 3-digit BCD with a
// sequential double-dabble FSM and scans it onto a 4-digit active-low 7-seg display.
module score_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        CLR,
    input  logic [7:0]  SCORE,
    input  logic        LD,
    output logic [11:0] BCD,
    output logic        BUSY,
    output logic        DONE,
    output logic [3:0]  AN,
    output logic [6:0]  SEGS
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state_q, state_d;
    logic          pend_q, pend_d;
    logic [2:0]    iter_q, iter_d;
    logic [19:0]   shreg_q, shreg_d;
    logic [19:0]   step;
    logic [11:0]   bcd_q, bcd_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    segs_q, segs_d;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // One double-dabble iteration: correct each BCD nibble, then shift left.
    function automatic logic [19:0] dabble_step(input logic [19:0] r);
        logic [19:0] t;
        t = {add3(r[19:16]), add3(r[15:12]), add3(r[11:8]), r[7:0]};
        return {t[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        iter_d  = iter_q;
        shreg_d = shreg_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        step    = dabble_step(shreg_q);
        case (state_q)
            IDLE: begin
                if (LD || pend_q) begin
                    shreg_d = {12'b0, SCORE};
                    pend_d  = 1'b0;
                    iter_d  = 3'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Requests arriving mid-conversion collapse into a single pending one.
                if (LD) pend_d = 1'b1;
                shreg_d = step;
                iter_d  = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    bcd_d   = step[19:8];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        idx_d  = idx_q;
        an_d   = 4'b1111;
        segs_d = 7'b1111111;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        // Display reads only the committed BCD, never the working shift register.
        case (idx_q)
            2'd0: begin
                an_d   = 4'b1110;
                segs_d = seg7(bcd_q[3:0]);
            end
            2'd1: begin
                if (bcd_q[11:8] != 4'd0 || bcd_q[7:4] != 4'd0) begin
                    an_d   = 4'b1101;
                    segs_d = seg7(bcd_q[7:4]);
                end
            end
            2'd2: begin
                if (bcd_q[11:8] != 4'd0) begin
                    an_d   = 4'b1011;
                    segs_d = seg7(bcd_q[11:8]);
                end
            end
            default: begin
                an_d   = 4'b1111;
                segs_d = 7'b1111111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            iter_q  <= 3'd0;
            bcd_q   <= 12'd0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            an_q    <= 4'b1110;
            segs_q  <= 7'b1000000;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            segs_q  <= segs_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign BCD  = bcd_q;
    assign BUSY = (state_q == SHIFT);
    assign DONE = done_q;
    assign AN   = an_q;
    assign SEGS = segs_q;

endmodule
